// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in serial-out transmitter with a valid/ready load port.
// Define PISO_PARITY_EN to append an even-parity bit period after each word.
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic [1:0]       o_dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01
`ifdef PISO_PARITY_EN
        ,
        PARITY = 2'b10
`endif
    } state_t;

    // Handshake: a word moves when load_valid and load_ready are both high at
    // a rising edge; load_ready depends only on state and reset, never on valid.
    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_sout;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_sout_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_accept;
    logic             w_din_first;
    logic [WIDTH-1:0] w_din_adv;
    logic             w_shift_head;
    logic [WIDTH-1:0] w_shift_adv;

`ifdef PISO_PARITY_EN
    logic             r_parity;
    logic             w_parity_nxt;
`endif

    assign load_ready  = (r_state == IDLE) && reset;
    assign w_accept    = load_valid && load_ready;
    assign sout        = r_sout;
    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;

    // The shift register always holds the bits not yet driven, already aligned
    // so the next bit to send sits at the head position.
    assign w_din_first  = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign w_din_adv    = MSB_FIRST ? {din[WIDTH-2:0], 1'b0} : {1'b0, din[WIDTH-1:1]};
    assign w_shift_head = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    assign w_shift_adv  = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_sout_nxt  = r_sout;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
`ifdef PISO_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            IDLE: begin
                w_sout_nxt = 1'b0;
                w_busy_nxt = 1'b0;
                if (w_accept) begin
                    w_state_nxt = SHIFT;
                    w_shift_nxt = w_din_adv;
                    w_cnt_nxt   = '0;
                    w_sout_nxt  = w_din_first;
                    w_busy_nxt  = 1'b1;
`ifdef PISO_PARITY_EN
                    w_parity_nxt = ^din;
`endif
                end
            end
            SHIFT: begin
                if (r_cnt == LAST) begin
`ifdef PISO_PARITY_EN
                    w_state_nxt = PARITY;
                    w_sout_nxt  = r_parity;
`else
                    w_state_nxt = IDLE;
                    w_sout_nxt  = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
`endif
                end else begin
                    w_sout_nxt  = w_shift_head;
                    w_shift_nxt = w_shift_adv;
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                w_state_nxt = IDLE;
                w_sout_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
            end
`endif
            default: begin
                w_state_nxt = IDLE;
                w_shift_nxt = '0;
                w_cnt_nxt   = '0;
                w_sout_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_sout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sout  <= w_sout_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_piso_shift_tx.sv
// Testbench for piso_shift_tx: two instances (8-bit MSB-first, 4-bit LSB-first),
// scoreboard of expected serial sequences checked by per-instance monitors.
module tb_piso_shift_tx;

    localparam int W0 = 8;
    localparam bit M0 = 1'b1;
    localparam int W1 = 4;
    localparam bit M1 = 1'b0;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic          clk;
    logic          reset;
    logic          lv0, lr0, sout0, busy0, done0;
    logic [W0-1:0] din0;
    logic [1:0]    dbg0;
    logic          lv1, lr1, sout1, busy1, done1;
    logic [W1-1:0] din1;
    logic [1:0]    dbg1;

    int          cyc;
    int          n_checks;
    int          n_pass;
    logic [63:0] exp_q0[$];
    logic [63:0] exp_q1[$];
    int          acc_q0[$];
    int          acc_q1[$];
    logic [63:0] col[2];
    int          nb[2];
    bit          prev_done[2];

    piso_shift_tx #(.WIDTH(W0), .MSB_FIRST(M0)) u_dut0 (
        .clk(clk), .reset(reset), .load_valid(lv0), .load_ready(lr0), .din(din0),
        .sout(sout0), .busy(busy0), .done(done0), .o_dbg_state(dbg0)
    );

    piso_shift_tx #(.WIDTH(W1), .MSB_FIRST(M1)) u_dut1 (
        .clk(clk), .reset(reset), .load_valid(lv1), .load_ready(lr1), .din(din1),
        .sout(sout1), .busy(busy1), .done(done1), .o_dbg_state(dbg1)
    );

    // Clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: the serial bit sequence of a word, first-sent bit most significant.
    function automatic logic [63:0] model_seq(input int width, input bit msb_first,
                                              input logic [31:0] w);
        logic [63:0] s;
        int          ones;
        logic        p;
        s    = '0;
        ones = 0;
        for (int i = 0; i < width; i++) begin
            int k;
            k    = msb_first ? (width - 1 - i) : i;
            s    = {s[62:0], w[k]};
            ones = ones + int'(w[k]);
        end
        p = (ones % 2) == 1;
        if (PAR != 0) s = {s[62:0], p};
        return s;
    endfunction

    // Monitor: collects bits while busy, checks the word when done pulses.
    task automatic mon(input int id, input logic s, input logic b, input logic d,
                       input logic r, input logic [1:0] st);
        int          len;
        logic [63:0] e;
        int          a;
        bit          has;
        len = ((id == 0) ? W0 : W1) + PAR;
        if (!reset) begin
            chk($sformatf("rst_sout%0d", id), s, 0);
            chk($sformatf("rst_busy%0d", id), b, 0);
            chk($sformatf("rst_done%0d", id), d, 0);
            chk($sformatf("rst_ready%0d", id), r, 0);
            chk($sformatf("rst_state%0d", id), st, 0);
            col[id]       = '0;
            nb[id]        = 0;
            prev_done[id] = 1'b0;
            return;
        end
        if (b) begin
            col[id] = {col[id][62:0], s};
            nb[id]++;
            chk($sformatf("busy_ready%0d", id), r, 0);
        end else begin
            chk($sformatf("idle_sout%0d", id), s, 0);
        end
        if (d) begin
            chk($sformatf("done_width%0d", id), prev_done[id], 0);
            chk($sformatf("done_busy%0d", id), b, 0);
            chk($sformatf("done_ready%0d", id), r, 1);
            has = 1'b0;
            e   = '0;
            a   = 0;
            if (id == 0) begin
                if (exp_q0.size() > 0 && acc_q0.size() > 0) begin
                    has = 1'b1; e = exp_q0.pop_front(); a = acc_q0.pop_front();
                end
            end else begin
                if (exp_q1.size() > 0 && acc_q1.size() > 0) begin
                    has = 1'b1; e = exp_q1.pop_front(); a = acc_q1.pop_front();
                end
            end
            chk($sformatf("done_expected%0d", id), has, 1);
            if (has) begin
                chk($sformatf("nbits%0d", id), nb[id], len);
                chk($sformatf("word%0d", id), col[id], e);
                chk($sformatf("latency%0d", id), cyc - a, len);
            end
            col[id] = '0;
            nb[id]  = 0;
        end
        prev_done[id] = d;
    endtask

    always @(negedge clk) mon(0, sout0, busy0, done0, lr0, dbg0);
    always @(negedge clk) mon(1, sout1, busy1, done1, lr1, dbg1);

    // Driver: wait for ready at a falling edge, present the word, log the expectation.
    task automatic send(input int id, input logic [31:0] w, input bit hold);
        int t;
        t = 0;
        @(negedge clk);
        while (((id == 0) ? lr0 : lr1) != 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("send_ready%0d", id), (id == 0) ? lr0 : lr1, 1);
        if (((id == 0) ? lr0 : lr1) != 1'b1) return;
        if (id == 0) begin
            din0 = w[W0-1:0];
            lv0  = 1'b1;
            exp_q0.push_back(model_seq(W0, M0, w));
            acc_q0.push_back(cyc + 1);
        end else begin
            din1 = w[W1-1:0];
            lv1  = 1'b1;
            exp_q1.push_back(model_seq(W1, M1, w));
            acc_q1.push_back(cyc + 1);
        end
        @(negedge clk);
        if (!hold) begin
            if (id == 0) lv0 = 1'b0;
            else lv1 = 1'b0;
        end
    endtask

    initial begin
        int t;
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 2; i++) begin
            col[i] = '0; nb[i] = 0; prev_done[i] = 1'b0;
        end
        reset = 1'b0;
        lv0   = 1'b1;
        din0  = 8'hA5;
        lv1   = 1'b0;
        din1  = '0;

        // Reset held with valid high, then released between edges
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        send(0, 32'hA5, 0);
        send(1, 32'hB, 0);
        send(0, 32'h07, 0);

        // Hold valid and change din mid-word; next word follows after one idle clock
        send(0, 32'h3C, 1);
        din0 = 8'hFF;
        t = 0;
        @(negedge clk);
        while (!done0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("b2b_done", done0, 1);
        chk("b2b_ready", lr0, 1);
        exp_q0.push_back(model_seq(W0, M0, 32'hFF));
        acc_q0.push_back(cyc + 1);
        @(negedge clk);
        lv0 = 1'b0;
        chk("b2b_start_busy", busy0, 1);
        chk("b2b_start_sout", sout0, 1);

        // Asynchronous reset in the middle of a word
        send(0, 32'hFF, 0);
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("midrst_sout", sout0, 0);
        chk("midrst_busy", busy0, 0);
        chk("midrst_done", done0, 0);
        exp_q0.delete();
        acc_q0.delete();
        exp_q1.delete();
        acc_q1.delete();
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        send(0, 32'h01, 0);

        // Randomized words with random gaps on both instances
        for (int i = 0; i < 16; i++) begin
            send(0, $urandom, 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        for (int i = 0; i < 12; i++) begin
            send(1, $urandom, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        send(1, 32'h0, 0);
        send(1, 32'hF, 0);

        t = 0;
        while ((exp_q0.size() + exp_q1.size()) != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_q0.size() + exp_q1.size(), 0);
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
Parallel-in, serial-out bit transmitter. Accepts a WIDTH-bit word through a valid/ready load handshake and drives it out one bit per clock on a single serial line. The line behaves like a latch/flip-flop D input, held at 0 when idle. It is the source end of the serial data stream that the sequential storage cells (latches, flip-flops, shift-register receivers) consume.

Parameters:
WIDTH, 8, number of data bits per word (legal range 2..32)
MSB_FIRST, 1, 1 = din[WIDTH-1] is sent first; 0 = din[0] is sent first

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
load_valid  input  1  din holds a word to send
load_ready  output  1  block can accept a word this cycle
din  input  WIDTH  parallel word, sampled on the accepting edge
sout  output  1  serial data out, registered
busy  output  1  word transfer in progress, registered
done  output  1  one-cycle pulse after the last bit period, registered

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, sout=0, busy=0, done=0, bit counter=0, shift register=0. load_ready=0 while reset is low.
- load_ready = (state==IDLE) and reset==1. It is combinational from state only and never depends on load_valid.
- Accept: at a rising edge with load_valid=1 and load_ready=1:
  - din is captured into the shift register.
  - sout <= first bit, busy <= 1, state <= SHIFT, counter <= 0.
- SHIFT:
  - Each rising edge advances one bit: sout <= next bit and counter increments.
  - Each bit is held on sout for exactly one clock period.
  - Bit order follows MSB_FIRST.
- End of word: on the edge that ends the last bit period (counter==WIDTH-1):
  - state <= IDLE, sout <= 0, busy <= 0, done <= 1.
  - done returns to 0 on the following edge.
- Latency: the first bit appears on sout one clock after acceptance. The word occupies WIDTH clocks of sout; done is high in clock WIDTH+1 after acceptance.
- Back-to-back: load_ready is 1 in the same cycle done is high. A word accepted then starts on the next clock, so there is exactly one idle (sout=0) clock between words.
- load_valid while busy: ignored, no effect on the shifting word. din changes after acceptance do not affect the word.
- Reset mid-word: the word is abandoned immediately, sout=0, and no done pulse is produced. After reset is released the block is in IDLE, ready for a new load.
- States: IDLE, SHIFT (plus PARITY when the optional feature is compiled in). No other reachable states. Any illegal encoding returns to IDLE on the next edge.

Optional Feature:
PISO_PARITY_EN
- Defined: after the last data bit, one extra bit period (state PARITY) drives the even-parity bit, i.e. the XOR of all WIDTH data bits.
  - Word length becomes WIDTH+1 clocks.
  - done is asserted after the parity period.
- Not defined: the PARITY state and parity logic are absent and the timing is exactly as in Behaviour.

Test Plan:
1. reset=0 for 2 clocks with load_valid=1, then released -> sout=0, busy=0, done=0, load_ready=0 during reset; load_ready=1 on the first clock after release.
2. WIDTH=8, MSB_FIRST=1, accept din=8'hA5 -> sout=1,0,1,0,0,1,0,1 on the 8 clocks after acceptance; busy=1 throughout; done=1 in the 9th clock; then sout=0.
3. WIDTH=4, MSB_FIRST=0, accept din=4'hB -> sout=1,1,0,1; done pulse width exactly 1 clock.
4. Accept 8'h3C, hold load_valid=1 and change din to 8'hFF mid-word -> sout=0,0,1,1,1,1,0,0 unaffected; next word 8'hFF starts after exactly one idle clock.
5. Accept 8'hFF, drive reset=0 asynchronously (between edges) after 3 bits -> sout and busy drop to 0 immediately; no done pulse; after release, 8'h01 sends 0,0,0,0,0,0,0,1.
6. With PISO_PARITY_EN defined: 8'hA5 -> 8 data bits then parity 0; 8'h07 -> data bits then parity 1; done in clock 10 after acceptance.
